// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: frame sequencer for an oversampled UART receiver.
// The edge/bit counters and the start/parity/stop checkers sit outside this
// block. This FSM runs the counters, strobes the checkers at the last
// oversample of each bit, and flags an accepted frame with data_valid.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | line idle, counters held clear, waiting for RX_IN low
// START  | start bit; checked for a glitch at its last oversample
// DATA   | DATA_WIDTH data bits; deserializer strobed once per bit
// PARITY | parity bit (only when latched parity enable is set)
// STOP   | stop bit; stop checker result captured
// DONE   | one cycle; data_valid if no parity/stop error was seen
module uart_rx_fsm #(
    parameter int DATA_WIDTH = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic       PAR_EN,
    input  logic [5:0] Prescale,
    input  logic [5:0] edge_cnt,
    input  logic [3:0] bit_cnt,
    input  logic       strt_glitch,
    input  logic       par_err,
    input  logic       stp_err,
    output logic       enable,
    output logic       dat_samp_en,
    output logic       deser_en,
    output logic       strt_chk_en,
    output logic       par_chk_en,
    output logic       stp_chk_en,
    output logic       data_valid
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    localparam logic [3:0] LAST_DATA_BIT = 4'(DATA_WIDTH);

    logic [2:0] r_state;
    logic [2:0] w_next_state;
    logic       r_par_en_q;
    logic       r_perr_q;
    logic       r_serr_q;
    logic       w_last;
    logic       w_data_done;
    logic       w_start_entry;

    // Prescale-1 stays 6 bits wide so Prescale=32 compares against 31 exactly.
    assign w_last = (edge_cnt == (Prescale - 6'd1));

    // ">=" rather than "==" so a mid-frame Prescale change that skips past the
    // last data bit still leaves DATA instead of waiting for bit_cnt to wrap.
    assign w_data_done = (bit_cnt >= LAST_DATA_BIT);

    assign w_start_entry = (w_next_state == ST_START) && (r_state != ST_START);

    // Next-state decode; unused encodings fall back to IDLE.
    always_comb begin
        w_next_state = ST_IDLE;
        case (r_state)
            ST_IDLE: begin
                w_next_state = RX_IN ? ST_IDLE : ST_START;
            end
            ST_START: begin
                if (!w_last)
                    w_next_state = ST_START;
                else if (strt_glitch)
                    w_next_state = ST_IDLE;
                else
                    w_next_state = ST_DATA;
            end
            ST_DATA: begin
                if (w_last && w_data_done)
                    w_next_state = r_par_en_q ? ST_PARITY : ST_STOP;
                else
                    w_next_state = ST_DATA;
            end
            ST_PARITY: begin
                w_next_state = w_last ? ST_STOP : ST_PARITY;
            end
            ST_STOP: begin
                w_next_state = w_last ? ST_DONE : ST_STOP;
            end
            ST_DONE: begin
                w_next_state = RX_IN ? ST_IDLE : ST_START;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            r_state <= ST_IDLE;
        else
            r_state <= w_next_state;
    end

    // Per-frame flags: parity enable frozen at START entry, error flags
    // cleared there and set by the checkers at the last oversample.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_par_en_q <= 1'b0;
            r_perr_q   <= 1'b0;
            r_serr_q   <= 1'b0;
        end else if (w_start_entry) begin
            r_par_en_q <= PAR_EN;
            r_perr_q   <= 1'b0;
            r_serr_q   <= 1'b0;
        end else begin
            if ((r_state == ST_PARITY) && w_last && par_err)
                r_perr_q <= 1'b1;
            if ((r_state == ST_STOP) && w_last)
                r_serr_q <= stp_err;
        end
    end

    // Output decode from registered state and counter values only.
    always_comb begin
        enable      = 1'b0;
        dat_samp_en = 1'b0;
        deser_en    = 1'b0;
        strt_chk_en = 1'b0;
        par_chk_en  = 1'b0;
        stp_chk_en  = 1'b0;
        data_valid  = 1'b0;
        case (r_state)
            ST_START: begin
                enable      = 1'b1;
                dat_samp_en = 1'b1;
                strt_chk_en = w_last;
            end
            ST_DATA: begin
                enable      = 1'b1;
                dat_samp_en = 1'b1;
                deser_en    = w_last;
            end
            ST_PARITY: begin
                enable      = 1'b1;
                dat_samp_en = 1'b1;
                par_chk_en  = w_last;
            end
            ST_STOP: begin
                enable      = 1'b1;
                dat_samp_en = 1'b1;
                stp_chk_en  = w_last;
            end
            ST_DONE: begin
                data_valid  = !r_perr_q && !r_serr_q;
            end
            default: begin
                enable      = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/uart_rx_fsm.md
UART_RX_FSM -- requirements
Module: uart_rx_fsm

Interface
REQ-001 Parameter: DATA_WIDTH, 8, number of data bits per frame.
REQ-002 Port: CLK  in  1  receiver clock; all state updates on rising edge.
REQ-003 Port: RST  in  1  reset, asynchronous and active-low.
REQ-004 Port: RX_IN  in  1  serial line; idle high.
REQ-005 Port: PAR_EN  in  1  parity bit present in frame when 1.
REQ-006 Port: Prescale  in  6  oversampling ratio; legal values 8, 16, 32.
REQ-007 Port: edge_cnt  in  6  edge counter value, 0..Prescale-1 within a bit.
REQ-008 Port: bit_cnt  in  4  bit counter value; 0 = start bit, 1..DATA_WIDTH = data, then parity, then stop.
REQ-009 Port: strt_glitch, par_err, stp_err  in  1 each  checker results, valid in the same cycle as the matching check enable.
REQ-010 Port: enable  out  1  edge/bit counter run; counters clear while 0.
REQ-011 Port: dat_samp_en  out  1  data-sampling enable.
REQ-012 Port: deser_en  out  1  deserializer shift strobe.
REQ-013 Port: strt_chk_en, par_chk_en, stp_chk_en  out  1 each  checker strobes.
REQ-014 Port: data_valid  out  1  frame accepted; single-cycle pulse.

Function
REQ-015 States: IDLE, START, DATA, PARITY, STOP, DONE; binary encoded; next state registered.
REQ-016 Define LAST = (edge_cnt == Prescale-1); compared at 6-bit width, no truncation.
REQ-017 IDLE: all outputs 0; RX_IN==0 -> START next cycle; PAR_EN latched into par_en_q on this transition.
REQ-018 START/DATA/PARITY/STOP: enable=1 and dat_samp_en=1 for every cycle in state.
REQ-019 START: strt_chk_en=1 only when LAST; LAST & strt_glitch -> IDLE; LAST & !strt_glitch -> DATA.
REQ-020 DATA: deser_en=1 only when LAST (exactly DATA_WIDTH strobes per frame); LAST & bit_cnt==DATA_WIDTH -> PARITY if par_en_q else STOP.
REQ-021 PARITY: par_chk_en=1 only when LAST; LAST -> STOP; par_err captured into sticky flag perr_q.
REQ-022 STOP: stp_chk_en=1 only when LAST; LAST -> DONE; stp_err captured into serr_q.
REQ-023 DONE: one cycle; enable=0; data_valid=1 iff !perr_q & !serr_q; then RX_IN==0 -> START (back-to-back frame, par_en_q re-latched), else IDLE.
REQ-024 data_valid, and all enables, are decoded from registered state/counters only; no path from RX_IN to any output.
REQ-025 perr_q/serr_q cleared on entry to START.
REQ-026 PAR_EN change mid-frame has no effect until next START entry.
REQ-027 Start glitch: no deser_en, no data_valid; line re-armed in IDLE with counters cleared (enable=0) the following cycle.
REQ-028 Prescale change mid-frame: undefined frame, FSM shall still reach IDLE or DONE; no lock-up state; unused encodings -> IDLE.
REQ-029 Frame length in cycles (start detect to DONE) = Prescale*(2+DATA_WIDTH+par_en_q) + 1.

Reset
REQ-030 RST low asynchronously forces IDLE, par_en_q=0, perr_q=0, serr_q=0; all outputs 0 while RST low.
REQ-031 RST asserted mid-frame aborts the frame with no data_valid; after release FSM waits for RX_IN falling to 0.
REQ-032 RST deasserts synchronously to CLK externally; first decision in IDLE occurs on first edge after release.

Verification
REQ-033 Prescale=8, PAR_EN=0, byte 0xA5, good stop -> 8 deser_en pulses, one data_valid in cycle 81 after start detect.
REQ-034 Prescale=16, PAR_EN=1, even-parity byte 0x3C, checker par_err=1 -> par_chk_en once, data_valid stays 0, return to IDLE.
REQ-035 Prescale=32, start bit low for 4 cycles only (strt_glitch=1 at LAST) -> back to IDLE, zero deser_en, zero data_valid.
REQ-036 Two back-to-back frames, Prescale=8, PAR_EN=1, stop_err=1 on first -> first no data_valid, second data_valid=1, START entered directly from DONE.
REQ-037 RST low at bit_cnt=4 of DATA -> all outputs 0 immediately, IDLE after release, next clean frame accepted.
REQ-038 PAR_EN toggled 1->0 during DATA with par_en_q=1 -> PARITY still visited, frame length per REQ-029 with parity.
